alu_uart_interface: RTL and testbench

Upstream/downstream glue for the ALU. It collects a 3-byte command frame from the UART receiver: operand A, then operand B, then the opcode byte. It drives the ALU operand and opcode inputs, captures the ALU result and flags, and returns them to the UART transmitter as two bytes. It replaces the switch/button loading path (three data enables) so the ALU can be exercised over the serial link.

---
 rtl/alu_uart_interface.sv | 143 ++++++++++++++
 tb/tb_alu_uart_interface.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_interface.sv
// Purpose: collects an A/B/opcode frame from the UART RX, drives the ALU, and returns the result and flags bytes over UART TX.
// Latency: after the opcode byte, o_alu_op is valid 1 cycle later and the result byte o_tx_start pulses 2 cycles later.
// Backpressure: each TX byte waits for i_tx_done; RX bytes that arrive while busy are dropped and flagged in the sticky o_rx_overrun.
module alu_uart_interface #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_carry,
    input  logic               i_alu_zero,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_rx_overrun
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
    } state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [1:0]         flags_q, flags_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Next-state logic: frame collection, inter-byte timeout, execute and two-byte response
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        flags_d    = flags_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        cnt_d      = '0;
        case (state_q)
            WAIT_A: begin
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                // an arriving byte wins over a simultaneous timeout
                if (i_rx_done) begin
                    b_d     = i_rx_data;
                    state_d = WAIT_OP;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[NB_DATA-1 -: NB_OP];
                    state_d = EXEC;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                // ALU has had one cycle to settle on the new operands
                tx_data_d  = i_alu_result;
                flags_d    = {i_alu_carry, i_alu_zero};
                tx_start_d = 1'b1;
                state_d    = SEND_RES;
            end
            SEND_RES: state_d = WAIT_RES;
            WAIT_RES: begin
                if (i_tx_done) state_d = SEND_FLG;
            end
            SEND_FLG: begin
                tx_data_d  = {{(NB_DATA-2){1'b0}}, flags_q};
                tx_start_d = 1'b1;
                state_d    = WAIT_FLG;
            end
            WAIT_FLG: begin
                if (i_tx_done) state_d = WAIT_A;
            end
            default: state_d = WAIT_A;
        endcase
        busy_d    = (state_d == EXEC) || (state_d == SEND_RES) || (state_d == WAIT_RES) ||
                    (state_d == SEND_FLG) || (state_d == WAIT_FLG);
        overrun_d = overrun_q | (i_rx_done & busy_q);
    end

    // State and output registers; synchronous reset drops any partial frame and pending TX pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            flags_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            flags_q    <= flags_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_alu_data_a = a_q;
    assign o_alu_data_b = b_q;
    assign o_alu_op     = op_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = busy_q;
    assign o_rx_overrun = overrun_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: directed frames plus random frames against an arithmetic reference.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// A small ALU model closes the loop from o_alu_* back to i_alu_*.
module tb_alu_uart_interface;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_a, alu_b, alu_result, tx_data;
    logic [5:0] alu_op;
    logic       alu_carry, alu_zero;
    logic       tx_start, tx_done, busy, ovr;

    int   checks = 0;
    int   errors = 0;
    logic exp_ovr = 1'b0;

    always #5 clk = ~clk;

    alu_uart_interface #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_alu_data_a(alu_a), .o_alu_data_b(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_result), .i_alu_carry(alu_carry), .i_alu_zero(alu_zero),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
        .o_busy(busy), .o_rx_overrun(ovr)
    );

    // ALU stand-in: carry is bit 8 of the extended operation
    logic [8:0] alu_ext;
    always_comb begin
        alu_ext = 9'h000;
        case (alu_op)
            6'b100000: alu_ext = {1'b0, alu_a} + {1'b0, alu_b};
            6'b100010: alu_ext = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            6'b100100: alu_ext = {1'b0, alu_a & alu_b};
            6'b100101: alu_ext = {1'b0, alu_a | alu_b};
            6'b100110: alu_ext = {1'b0, alu_a ^ alu_b};
            default:   alu_ext = 9'h15A;
        endcase
    end
    assign alu_result = alu_ext[7:0];
    assign alu_carry  = alu_ext[8];
    assign alu_zero   = (alu_ext[7:0] == 8'h00);

    // Expected response bytes from plain integer arithmetic
    function automatic void ref_model(input int a, input int b, input int op,
                                      output int res, output int flg);
        int c;
        c = 0;
        case (op)
            32: begin res = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
            34: begin res = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
            36: res = a & b;
            37: res = a | b;
            38: res = a ^ b;
            default: begin res = 90; c = 1; end
        endcase
        flg = c * 2 + ((res == 0) ? 1 : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_op"}, alu_op, 0);
        chk({tag, "_txd"}, tx_data, 0);
        chk({tag, "_start"}, tx_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovr"}, ovr, 0);
    endtask

    // mode 0 normal, 1 overrun byte in WAIT_RES, 2 reset in SEND_FLG, 3 reset in WAIT_FLG
    task automatic run_frame(input int a, input int b, input int opb,
                             input int mode, input int dly, input int gap);
        int er, ef;
        ref_model(a, b, opb >> 2, er, ef);
        send_byte(8'(a));
        tick(gap);
        send_byte(8'(b));
        tick(gap);
        send_byte(8'(opb));
        chk("exec_op", alu_op, opb >> 2);
        chk("exec_a", alu_a, a);
        chk("exec_b", alu_b, b);
        chk("exec_busy", busy, 1);
        chk("exec_start", tx_start, 0);
        tick(1);
        chk("res_start", tx_start, 1);
        chk("res_data", tx_data, er);
        if (mode == 1) begin
            tick(1);
            send_byte(8'h3C);
            exp_ovr = 1'b1;
            chk("ovr_set", ovr, 1);
            chk("ovr_a_kept", alu_a, a);
        end
        tick(dly);
        chk("res_hold", tx_data, er);
        chk("res_start_low", tx_start, 0);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        if (mode == 2) begin
            reset = 1'b1;
            tick(1);
            reset = 1'b0;
            exp_ovr = 1'b0;
            chk_reset("rst_sendflg");
            tick(1);
            chk("rst_sendflg_nostart", tx_start, 0);
            return;
        end
        chk("flg_gap", tx_start, 0);
        tick(1);
        chk("flg_start", tx_start, 1);
        chk("flg_data", tx_data, ef);
        if (mode == 3) begin
            reset = 1'b1;
            tick(1);
            reset = 1'b0;
            exp_ovr = 1'b0;
            chk_reset("rst_waitflg");
            tx_done = 1'b1;
            tick(1);
            tx_done = 1'b0;
            chk("rst_waitflg_busy", busy, 0);
            chk("rst_waitflg_nostart", tx_start, 0);
            return;
        end
        tick(dly);
        chk("flg_hold", tx_data, ef);
        chk("flg_busy", busy, 1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("end_busy", busy, 0);
        chk("end_ovr", ovr, exp_ovr);
    endtask

    logic [7:0] op_tab [6] = '{8'h80, 8'h88, 8'h90, 8'h94, 8'h98, 8'hFC};

    initial begin
        reset   = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        tick(2);
        chk_reset("reset");
        reset = 1'b0;
        tick(1);

        // directed frames; the ADD frame is followed back-to-back by 0 - 1
        run_frame(50, 20, 8'h88, 0, 2, 0);
        run_frame(25, 25, 8'h88, 0, 1, 0);
        run_frame(10, 20, 8'h88, 0, 3, 0);
        run_frame(200, 100, 8'h80, 0, 1, 0);
        run_frame(0, 1, 8'h88, 0, 1, 0);

        // partial frame dropped after TMO idle cycles in WAIT_OP
        send_byte(8'd50);
        send_byte(8'd20);
        for (int i = 0; i < TMO; i++) begin
            tick(1);
            chk("tmo_nostart", tx_start, 0);
        end
        chk("tmo_busy", busy, 0);
        chk("tmo_a_kept", alu_a, 50);
        chk("tmo_b_kept", alu_b, 20);
        run_frame(7, 3, 8'h88, 0, 1, 0);

        // byte landing on the last counter value is still accepted
        run_frame(11, 22, 8'h90, 0, 1, TMO - 1);

        // overrun during WAIT_RES; flag stays set in later frames
        run_frame(9, 4, 8'h98, 1, 3, 0);
        run_frame(1, 2, 8'h94, 0, 1, 0);

        // random frames, including an opcode the ALU does not know
        for (int k = 0; k < 8; k++) begin
            int a, b, opb;
            a   = int'($urandom_range(0, 255));
            b   = int'($urandom_range(0, 255));
            opb = int'(op_tab[$urandom_range(0, 5)]) | int'($urandom_range(0, 3));
            run_frame(a, b, opb, 0, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
        end

        // reset mid-response
        run_frame(30, 12, 8'h88, 2, 1, 0);
        run_frame(5, 5, 8'h80, 0, 1, 0);
        run_frame(100, 7, 8'h88, 3, 2, 0);
        run_frame(255, 1, 8'h80, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
